pixel_addr_gen: RTL
===================

# pixel_addr_gen

Parametrised frame-buffer read-address generator between the VGA timing counters and the source-image BRAM. It maps the display coordinate (hcount_in, vcount_in) to a linear source pixel address. It supports integer upscale (1x/2x/4x), independent horizontal and vertical mirroring, and a positionable display window with an in-window flag. Configuration is shadowed and only takes effect at frame start, so a mode change never tears mid-frame.

## Interface
Parameters:
- SRC_W, 240, source image width in pixels
- SRC_H, 320, source image height in pixels
- H_BITS, 11, hcount width
- V_BITS, 10, vcount width
- ADDR_W, 17, address width; must satisfy 2^ADDR_W >= SRC_W*SRC_H

Ports:
- clk_in  input  1  pixel clock
- rst_n_in  input  1  reset, asynchronous, active-low
- valid_in  input  1  hcount_in/vcount_in qualify a pixel this cycle
- hcount_in  input  H_BITS  display x
- vcount_in  input  V_BITS  display y
- scale_in  input  2  0=1x, 1=2x, 2=4x, 3=reserved (treated as 1x)
- mirror_h_in  input  1  flip horizontally
- mirror_v_in  input  1  flip vertically
- x_off_in  input  H_BITS  window left edge (display x)
- y_off_in  input  V_BITS  window top edge (display y)
- pixel_addr_out  output  ADDR_W  source address, row-major (y*SRC_W + x)
- in_window_out  output  1  pixel lies inside the window
- valid_out  output  1  pixel_addr_out/in_window_out valid

## Operation
- Shadow registers:
  - Hold scale, mirror_h, mirror_v, x_off and y_off.
  - Load when valid_in && hcount_in==0 && vcount_in==0 (frame start).
  - The loaded values apply to that same pixel onward.
  - Configuration input changes at any other time are ignored until the next frame start.
- Window math for scale factor S = 1, 2 or 4 (k = log2 S):
  - dx = hcount - x_off, dy = vcount - y_off, signed, one bit wider than the operands.
  - In window iff dx >= 0, dy >= 0, dx < SRC_W*S and dy < SRC_H*S.
  - sx = dx >> k, sy = dy >> k. No dividers.
- Mirror: sx' = SRC_W-1-sx when mirror_h, else sx; sy' = SRC_H-1-sy when mirror_v, else sy. Result always lies in 0..SRC_W-1 and 0..SRC_H-1.
- Address: pixel_addr_out = sy'*SRC_W + sx'. Maximum value is SRC_W*SRC_H-1; no wrap.
- Outside the window: pixel_addr_out = 0, in_window_out = 0.
- valid_in=0: the pipeline still advances; valid_out=0 for that slot. Data lanes hold don't-care but deterministic values.

## Timing
- Latency: fixed 3 cycles from valid_in to valid_out. Throughput 1 pixel/cycle, no stalls.
  - Stage 1: offset subtract, window compare, shift.
  - Stage 2: mirror, multiply sy'*SRC_W.
  - Stage 3: add and register outputs.
- Reset values (all asynchronous on rst_n_in low):
  - Outputs: pixel_addr_out=0, in_window_out=0, valid_out=0.
  - Shadow registers: scale=1x, mirrors=0, offsets=0.
  - All pipeline valid bits cleared.
- Reset mid-frame: in-flight pixels are discarded. After release, the shadow keeps its reset defaults until the next frame start.
- Frame start and a config change in the same cycle: the new values are captured and used for pixel (0,0).
- Boundary pixels:
  - dx = SRC_W*S-1 is inside the window; dx = SRC_W*S is outside.
  - Offset 0 with hcount=0 gives dx=0, which is inside.

## Structure
- Package pixel_addr_pkg holds:
  - typedef scale_e (SCALE_1X, SCALE_2X, SCALE_4X, SCALE_RSVD).
  - A shadow-config struct type.
  - The function scale_shift(scale_e) returning k.
- One natural sub-module, addr_cfg_shadow: holds the frame-start latch of the config struct, with asynchronous active-low reset. The main module holds the 3-stage pipeline.

## Test plan
- Default config, 1x, offsets 0: (h=5, v=2) -> addr 485, in_window=1, valid_out 3 cycles later. (h=240, v=0) -> in_window=0, addr 0.
- 2x, mirror_h, offsets 0: (h=0, v=0) -> addr 239. (h=3, v=5) -> sx=1, sy=2, addr 718.
- 4x, mirror_v, x_off=100, y_off=10: (h=100, v=10) -> addr 319*240 = 76560. (h=99, v=10) -> in_window=0. (h=1059, v=10) -> in_window=1, sx=239; (h=1060, v=10) -> in_window=0.
- Mid-frame config: change scale to 2x at (h=10, v=50). The rest of the frame still uses the 1x mapping. At the next (0,0) the 2x mapping takes effect on that same pixel.
- Reset mid-stream: assert rst_n_in while valid_in pixels are in flight. Outputs go to 0 immediately (asynchronously). No valid_out appears for the discarded pixels after release.
- scale_in=3: behaves identically to 1x for a sweep of 100 random coordinates; compare against a reference model with a zero-latency check shifted by 3 cycles.

Source files
------------

// File: rtl/pixel_addr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_addr_pkg
// Description : Shared types and helpers for the frame-buffer read-address
//               generator: scale encoding, shadowed configuration record and
//               scale-to-shift conversion.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_addr_pkg;

    // Offsets are carried at a fixed width in the configuration record; the
    // top level zero-extends its H_BITS/V_BITS offsets into these fields.
    localparam int CFG_OFF_W = 16;

    typedef enum logic [1:0] {
        SCALE_1X   = 2'd0,
        SCALE_2X   = 2'd1,
        SCALE_4X   = 2'd2,
        SCALE_RSVD = 2'd3
    } scale_e;

    typedef struct packed {
        scale_e                 scale;
        logic                   mirror_h;
        logic                   mirror_v;
        logic [CFG_OFF_W-1:0]   x_off;
        logic [CFG_OFF_W-1:0]   y_off;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{
        scale    : SCALE_1X,
        mirror_h : 1'b0,
        mirror_v : 1'b0,
        x_off    : '0,
        y_off    : '0
    };

    // log2 of the upscale factor; the reserved code maps to 1x.
    function automatic logic [1:0] scale_shift(input scale_e s);
        logic [1:0] k;
        case (s)
            SCALE_2X: k = 2'd1;
            SCALE_4X: k = 2'd2;
            default:  k = 2'd0;
        endcase
        return k;
    endfunction

endpackage : pixel_addr_pkg
`default_nettype wire

// File: rtl/addr_cfg_shadow.sv
`default_nettype none
// ============================================================================
// Module      : addr_cfg_shadow
// Description : Frame-start latch for the address-generator configuration.
//               The incoming configuration is bypassed to the output in the
//               load cycle so the frame's first pixel already sees it.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_cfg_shadow
    import pixel_addr_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    input  cfg_t cfg_i,
    output cfg_t cfg_o
);

    cfg_t cfg_q;

    // Capture the requested configuration only at frame start.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cfg_q <= CFG_RESET;
        end else if (load_i) begin
            cfg_q <= cfg_i;
        end
    end

    // Same-cycle bypass: pixel (0,0) uses the values being loaded.
    assign cfg_o = load_i ? cfg_i : cfg_q;

endmodule : addr_cfg_shadow
`default_nettype wire

// File: rtl/pixel_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : pixel_addr_gen
// Description : Maps VGA display coordinates to a row-major source-image
//               address with 1x/2x/4x upscale, H/V mirroring and a movable
//               display window. Three-stage pipeline, one pixel per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_addr_gen
    import pixel_addr_pkg::*;
#(
    parameter int SRC_W  = 240,
    parameter int SRC_H  = 320,
    parameter int H_BITS = 11,
    parameter int V_BITS = 10,
    parameter int ADDR_W = 17
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              valid_in,
    input  logic [H_BITS-1:0] hcount_in,
    input  logic [V_BITS-1:0] vcount_in,
    input  logic [1:0]        scale_in,
    input  logic              mirror_h_in,
    input  logic              mirror_v_in,
    input  logic [H_BITS-1:0] x_off_in,
    input  logic [V_BITS-1:0] y_off_in,
    output logic [ADDR_W-1:0] pixel_addr_out,
    output logic              in_window_out,
    output logic              valid_out
);

    localparam int SX_W = $clog2(SRC_W);
    localparam int SY_W = $clog2(SRC_H);

    // ------------------------------------------------------------------
    // Configuration shadow
    // ------------------------------------------------------------------
    logic w_frame_start;
    cfg_t w_cfg_req;
    cfg_t w_cfg;

    assign w_frame_start = valid_in && (hcount_in == '0) && (vcount_in == '0);

    // Pack the live configuration inputs into the shadow record.
    always_comb begin
        w_cfg_req          = CFG_RESET;
        w_cfg_req.scale    = scale_e'(scale_in);
        w_cfg_req.mirror_h = mirror_h_in;
        w_cfg_req.mirror_v = mirror_v_in;
        w_cfg_req.x_off    = CFG_OFF_W'(x_off_in);
        w_cfg_req.y_off    = CFG_OFF_W'(y_off_in);
    end

    addr_cfg_shadow u_cfg_shadow (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .load_i  (w_frame_start),
        .cfg_i   (w_cfg_req),
        .cfg_o   (w_cfg)
    );

    // Upper offset bits beyond H_BITS/V_BITS are always zero.
    logic w_unused_cfg_bits;
    assign w_unused_cfg_bits = ^{w_cfg.x_off, w_cfg.y_off};

    // ------------------------------------------------------------------
    // Stage 1: offset subtract, window compare, scale shift
    // ------------------------------------------------------------------
    logic signed [H_BITS:0] w_dx;
    logic signed [V_BITS:0] w_dy;
    logic [1:0]             w_k;
    logic                   s1_valid_d, s1_valid_q;
    logic                   s1_win_d,   s1_win_q;
    logic [SX_W-1:0]        s1_sx_d,    s1_sx_q;
    logic [SY_W-1:0]        s1_sy_d,    s1_sy_q;
    logic                   s1_mh_d,    s1_mh_q;
    logic                   s1_mv_d,    s1_mv_q;

    // Signed distances from the window corner; a set sign bit means left/above.
    always_comb begin
        w_k        = scale_shift(w_cfg.scale);
        w_dx       = $signed({1'b0, hcount_in}) - $signed({1'b0, w_cfg.x_off[H_BITS-1:0]});
        w_dy       = $signed({1'b0, vcount_in}) - $signed({1'b0, w_cfg.y_off[V_BITS-1:0]});
        s1_valid_d = valid_in;
        s1_win_d   = !w_dx[H_BITS] && !w_dy[V_BITS]
                     && (32'(w_dx[H_BITS-1:0]) < (32'(SRC_W) << w_k))
                     && (32'(w_dy[V_BITS-1:0]) < (32'(SRC_H) << w_k));
        s1_sx_d    = SX_W'(w_dx[H_BITS-1:0] >> w_k);
        s1_sy_d    = SY_W'(w_dy[V_BITS-1:0] >> w_k);
        s1_mh_d    = w_cfg.mirror_h;
        s1_mv_d    = w_cfg.mirror_v;
    end

    // Stage 1 register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_q <= 1'b0;
            s1_win_q   <= 1'b0;
            s1_sx_q    <= '0;
            s1_sy_q    <= '0;
            s1_mh_q    <= 1'b0;
            s1_mv_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_win_q   <= s1_win_d;
            s1_sx_q    <= s1_sx_d;
            s1_sy_q    <= s1_sy_d;
            s1_mh_q    <= s1_mh_d;
            s1_mv_q    <= s1_mv_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: mirror and row-base multiply
    // ------------------------------------------------------------------
    logic [SY_W-1:0]   w_sy_m;
    logic              s2_valid_d, s2_valid_q;
    logic              s2_win_d,   s2_win_q;
    logic [SX_W-1:0]   s2_sx_d,    s2_sx_q;
    logic [ADDR_W-1:0] s2_row_d,   s2_row_q;

    // Mirror reflects about the last source column/row; outside the window the
    // values are meaningless and are masked in stage 3.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_win_d   = s1_win_q;
        s2_sx_d    = s1_mh_q ? (SX_W'(SRC_W - 1) - s1_sx_q) : s1_sx_q;
        w_sy_m     = s1_mv_q ? (SY_W'(SRC_H - 1) - s1_sy_q) : s1_sy_q;
        s2_row_d   = ADDR_W'(w_sy_m) * ADDR_W'(SRC_W);
    end

    // Stage 2 register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s2_valid_q <= 1'b0;
            s2_win_q   <= 1'b0;
            s2_sx_q    <= '0;
            s2_row_q   <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_win_q   <= s2_win_d;
            s2_sx_q    <= s2_sx_d;
            s2_row_q   <= s2_row_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: final add, output register
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] s3_addr_d, s3_addr_q;
    logic              s3_win_d,  s3_win_q;
    logic              s3_valid_d, s3_valid_q;

    // Out-of-window pixels read address 0.
    always_comb begin
        s3_addr_d  = s2_win_q ? (s2_row_q + ADDR_W'(s2_sx_q)) : '0;
        s3_win_d   = s2_win_q;
        s3_valid_d = s2_valid_q;
    end

    // Output register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s3_addr_q  <= '0;
            s3_win_q   <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            s3_addr_q  <= s3_addr_d;
            s3_win_q   <= s3_win_d;
            s3_valid_q <= s3_valid_d;
        end
    end

    assign pixel_addr_out = s3_addr_q;
    assign in_window_out  = s3_win_q;
    assign valid_out      = s3_valid_q;

endmodule : pixel_addr_gen
`default_nettype wire
